// File: rtl/scpu_pkg.sv
// Shared definitions for the memory-bus arbiter.
// Contents: FSM state encoding, master IDs and memory-strobe bit positions.
package scpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_e;

  // Bit positions inside the registered memory-strobe vector.
  localparam int MEM_CE = 0;
  localparam int MEM_OE = 1;
  localparam int MEM_R  = 2;
  localparam int MEM_W  = 3;
  localparam int STRB_W = 4;

  function automatic master_e other_master(input master_e m);
    return (m == M_CPU) ? M_DMA : M_CPU;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant, bit 0 = CPU, bit 1 = DMA.
// On contention the master named by prio wins.
module rr_arbiter2
  import scpu_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    prio,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assign a default before any branch so no latch is inferred.
    grant = req;
    if (req == 2'b11) begin
      grant = (prio == M_CPU) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU and a DMA master.
// Each access runs a fixed SETUP -> ACCESS -> DONE sequence.
module mem_bus_arbiter
  import scpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_ce,
  output logic              mem_r,
  output logic              mem_oe,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  master_e           winner;
  master_e           prio;
  logic              we_q;
  logic [STRB_W-1:0] strb;
  logic [1:0]        grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_arb (
    .req   ({dma_req, cpu_req}),
    .prio  (prio),
    .grant (grant)
  );

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant[1]) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  assign mem_ce = strb[MEM_CE];
  assign mem_oe = strb[MEM_OE];
  assign mem_r  = strb[MEM_R];
  assign mem_w  = strb[MEM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= S_IDLE;
      winner    <= M_CPU;
      prio      <= M_CPU;
      we_q      <= 1'b0;
      strb      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant != 2'b00) begin
            winner       <= grant[1] ? M_DMA : M_CPU;
            we_q         <= sel_we;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            strb[MEM_CE] <= 1'b1;
            strb[MEM_R]  <= !sel_we;
            strb[MEM_W]  <= sel_we;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Reads swap the address strobe for output enable; writes keep w held.
          strb[MEM_R]  <= 1'b0;
          strb[MEM_OE] <= !we_q;
          state        <= S_ACCESS;
        end
        S_ACCESS: begin
          strb <= '0;
          if (winner == M_CPU) begin
            cpu_ack <= 1'b1;
            if (!we_q) cpu_rdata <= mem_rdata;
          end else begin
            dma_ack <= 1'b1;
            if (!we_q) dma_rdata <= mem_rdata;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          prio  <= other_master(winner);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
